dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: the core load/store path (c_*)
//  and a host loader port (h_*) used to preload operands before init and read back results.
//  Sits between both requesters and the memory instance; serialises accesses, one per grant.
//  Only block that drives memory_r_en / memory_w_en once instantiated.
// PARAMETERS
//  ADDR_W     8  memory address width
//  DATA_W     8  memory data width
//  HOST_PRIO  0  0: round-robin on simultaneous requests; 1: host always wins ties
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  init_n       in   1       asynchronous active-low reset
//  c_req        in   1       core access request; hold with c_we/c_addr/c_wdata until c_gnt
//  c_we         in   1       1 = store, 0 = load
//  c_addr       in   ADDR_W  core address
//  c_wdata      in   DATA_W  core store data
//  c_gnt        out  1       one-cycle pulse: core access being performed this cycle
//  c_rvalid     out  1       one-cycle pulse: c_rdata valid (loads only)
//  c_rdata      out  DATA_W  load data, registered, held until next core load completes
//  h_req/h_we/h_addr/h_wdata, h_gnt/h_rvalid/h_rdata: host port, identical semantics
//  mem_addr     out  ADDR_W  memory address (latched winner address)
//  mem_in       out  DATA_W  memory write data (latched winner data)
//  memory_r_en  out  1       memory read enable
//  memory_w_en  out  1       memory write enable
//  mem_out      in   DATA_W  memory read data, valid cycle after memory_r_en
// BEHAVIOUR
//  Reset (init_n=0, async): state IDLE; all gnt/rvalid/memory_*_en = 0; rdata, mem_addr,
//   mem_in = 0; rr_last = host (so core wins first tie). Takes effect without a clock edge.
//  FSM states: IDLE, ACCESS, RDATA.
//  IDLE: at edge with any req: pick winner, latch we/addr/wdata/owner -> ACCESS. No req: stay.
//   Arbitration: one req -> that one. Both: HOST_PRIO=1 -> host; else the one != rr_last.
//   rr_last updated to winner on every grant (also single-requester grants).
//  ACCESS (1 cycle): owner's gnt=1; memory_w_en=latched we; memory_r_en=!latched we.
//   Store -> IDLE. Load -> RDATA.
//  RDATA (1 cycle): owner's rdata <= mem_out and rvalid <= 1 at the exiting edge -> IDLE.
//   rvalid therefore high in the cycle after RDATA (coincides with IDLE), for one cycle.
//  memory_*_en, gnt decoded from state + latched regs only; never combinational from req.
//  Latency (req sampled at edge E0): gnt/mem enable in cycle E0..E1; store done at E1;
//   load rvalid in cycle E2..E3. Throughput: store every 2 cycles, load every 3.
//  Requester must drop req in its gnt cycle to avoid a second access; req still high at the
//   next IDLE edge is a new request (back-to-back access, arbitrated normally).
//  Req/addr changes while not granted: ignored until next IDLE sample; no latching earlier.
//  A requester never sees gnt or rvalid for an access it did not win; loser's req stays
//   pending and is guaranteed service on the next IDLE sample under round-robin.
//  Reset mid-ACCESS/RDATA: access aborted, no rvalid issued, memory enables drop at once;
//   a store in flight may or may not have been written (memory-side, not guaranteed).
//  Unused width/X on non-winning port inputs must not propagate to mem_* outputs.
// TESTING
//  1 core store 0x5A@0x10 alone -> c_gnt 1 cycle after req edge, memory_w_en=1 addr 0x10
//    same cycle, h_gnt stays 0; then core load 0x10 -> c_rvalid 2 cycles after gnt, rdata 0x5A.
//  2 both req stores every cycle, HOST_PRIO=0 -> grants alternate C,H,C,H from reset;
//    each gnt spaced 2 cycles; no double grant.
//  3 HOST_PRIO=1, both req held 3 grants -> H,H,H; core granted first IDLE after h_req drops.
//  4 host preload 0x01..0x04 @0x00..0x03, then core loads 0x00..0x03 -> rdata 01,02,03,04,
//    c_rvalid spaced 3 cycles; h_rdata unchanged.
//  5 init_n low during RDATA of a core load -> enables/gnt/rvalid 0 immediately, c_rvalid
//    never pulses, c_rdata=0; after release first req served normally.
//  6 core req held through gnt (not dropped) -> second identical access exactly 2 cycles
//    later; host req arriving meanwhile wins that tie under round-robin.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port data memory between the core (c_*) and host loader (h_*) ports.
// Latency: grant and memory enable in the cycle after the request edge; load data one cycle after that.
// Backpressure: a requester holds req until its gnt pulse; the losing requester stays pending, nothing is queued.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int HOST_PRIO = 0
) (
  input  logic              clk,
  input  logic              init_n,
  // core load/store port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // host loader port
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic              memory_r_en,
  output logic              memory_w_en,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  // One access request as presented by a requester.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_t state_q, state_d;
  logic   lat_we_q;
  logic   owner_q;
  logic   rr_last_q;

  req_t   c_r, h_r, win_r;
  logic   win_host;
  logic   take;
  logic   rd_done;

  assign c_r = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign h_r = '{we: h_we, addr: h_addr, wdata: h_wdata};

  // Arbitration: pick the winner and select only its fields, so the loser's inputs never reach mem_*.
  always_comb begin
    win_host = OWN_CORE;
    if (c_req && h_req) begin
      if (HOST_PRIO != 0) begin
        win_host = OWN_HOST;
      end else begin
        win_host = (rr_last_q == OWN_CORE) ? OWN_HOST : OWN_CORE;
      end
    end else if (h_req) begin
      win_host = OWN_HOST;
    end
    win_r = win_host ? h_r : c_r;
  end

  // Next-state and output decode; enables and grants depend only on state and latched owner/we.
  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    rd_done     = 1'b0;
    c_gnt       = 1'b0;
    h_gnt       = 1'b0;
    memory_w_en = 1'b0;
    memory_r_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (c_req || h_req) begin
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        c_gnt       = (owner_q == OWN_CORE);
        h_gnt       = (owner_q == OWN_HOST);
        memory_w_en = lat_we_q;
        memory_r_en = !lat_we_q;
        state_d     = lat_we_q ? IDLE : RDATA;
      end
      RDATA: begin
        rd_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE immediately, which drops every enable and grant.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning request and remember it for the next round-robin tie.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      lat_we_q  <= 1'b0;
      owner_q   <= OWN_CORE;
      rr_last_q <= OWN_HOST;
      mem_addr  <= '0;
      mem_in    <= '0;
    end else if (take) begin
      lat_we_q  <= win_r.we;
      owner_q   <= win_host;
      rr_last_q <= win_host;
      mem_addr  <= win_r.addr;
      mem_in    <= win_r.wdata;
    end
  end

  // Capture load data for the owner as RDATA exits; rvalid is a single-cycle pulse.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      c_rdata  <= '0;
      h_rdata  <= '0;
    end else begin
      c_rvalid <= rd_done && (owner_q == OWN_CORE);
      h_rvalid <= rd_done && (owner_q == OWN_HOST);
      if (rd_done && (owner_q == OWN_CORE)) begin
        c_rdata <= mem_out;
      end
      if (rd_done && (owner_q == OWN_HOST)) begin
        h_rdata <= mem_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed checks of dmem_arbiter grants, memory enables and load return on both ports.
// Latency: outputs compared 1 ns after each rising edge against hand-computed per-cycle values.
// Backpressure: requests are held or dropped per row to exercise pending losers and held requests.
module tb_dmem_arbiter;

  localparam int N = 0;  // no request
  localparam int S = 1;  // store
  localparam int L = 2;  // load

  typedef struct packed {
    logic       cg;
    logic       hg;
    logic       w;
    logic       r;
    logic [7:0] addr;
    logic [7:0] din;
    logic       crv;
    logic [7:0] crd;
    logic       hrv;
    logic [7:0] hrd;
  } obs_t;

  typedef struct {
    bit         rst;
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;
    obs_t       exp;
  } vec_t;

  logic       clk;
  logic       init_n;
  logic       c_req, c_we, h_req, h_we;
  logic [7:0] c_addr, c_wdata, h_addr, h_wdata;

  logic       c_gnt0, c_rvalid0, h_gnt0, h_rvalid0, r_en0, w_en0;
  logic [7:0] c_rdata0, h_rdata0, addr0, in0, mem_out0;
  logic       c_gnt1, c_rvalid1, h_gnt1, h_rvalid1, r_en1, w_en1;
  logic [7:0] c_rdata1, h_rdata1, addr1, in1;
  logic [7:0] mem [256];

  int pass_cnt = 0;
  int total_cnt = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIO(0)) dut0 (
    .clk(clk), .init_n(init_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt0), .c_rvalid(c_rvalid0), .c_rdata(c_rdata0),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt0), .h_rvalid(h_rvalid0), .h_rdata(h_rdata0),
    .mem_addr(addr0), .mem_in(in0), .memory_r_en(r_en0), .memory_w_en(w_en0),
    .mem_out(mem_out0)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIO(1)) dut1 (
    .clk(clk), .init_n(init_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt1), .c_rvalid(c_rvalid1), .c_rdata(c_rdata1),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt1), .h_rvalid(h_rvalid1), .h_rdata(h_rdata1),
    .mem_addr(addr1), .mem_in(in1), .memory_r_en(r_en1), .memory_w_en(w_en1),
    .mem_out(8'h00)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory behind dut0: read data valid the cycle after r_en.
  always @(posedge clk) begin
    if (w_en0) mem[addr0] <= in0;
    if (r_en0) mem_out0 <= mem[addr0];
  end

  function automatic obs_t get_obs();
    obs_t o;
    o = '{cg: c_gnt0, hg: h_gnt0, w: w_en0, r: r_en0, addr: addr0, din: in0,
          crv: c_rvalid0, crd: c_rdata0, hrv: h_rvalid0, hrd: h_rdata0};
    return o;
  endfunction

  function automatic obs_t ob(input int cg, input int hg, input int w, input int r,
                              input logic [7:0] addr, input logic [7:0] din,
                              input int crv, input logic [7:0] crd,
                              input int hrv, input logic [7:0] hrd);
    obs_t o;
    o = '{cg: (cg != 0), hg: (hg != 0), w: (w != 0), r: (r != 0), addr: addr, din: din,
          crv: (crv != 0), crd: crd, hrv: (hrv != 0), hrd: hrd};
    return o;
  endfunction

  function automatic vec_t mk(input bit rst, input int cop, input logic [7:0] ca,
                              input logic [7:0] cd, input int hop, input logic [7:0] ha,
                              input logic [7:0] hd, input obs_t e);
    vec_t v;
    v.rst   = rst;
    v.creq  = (cop != N);
    v.cwe   = (cop == S);
    v.caddr = ca;
    v.cwd   = cd;
    v.hreq  = (hop != N);
    v.hwe   = (hop == S);
    v.haddr = ha;
    v.hwd   = hd;
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s got cg=%b hg=%b w=%b r=%b addr=%h din=%h crv=%b crd=%h hrv=%b hrd=%h want cg=%b hg=%b w=%b r=%b addr=%h din=%h crv=%b crd=%h hrv=%b hrd=%h",
               name, got.cg, got.hg, got.w, got.r, got.addr, got.din, got.crv, got.crd, got.hrv, got.hrd,
               exp.cg, exp.hg, exp.w, exp.r, exp.addr, exp.din, exp.crv, exp.crd, exp.hrv, exp.hrd);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic check_bits(input string name, input logic [1:0] got, input logic [1:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s got {c,h}=%b want %b", name, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(input int cop, input logic [7:0] ca, input logic [7:0] cd,
                       input int hop, input logic [7:0] ha, input logic [7:0] hd);
    c_req = (cop != N); c_we = (cop == S); c_addr = ca; c_wdata = cd;
    h_req = (hop != N); h_we = (hop == S); h_addr = ha; h_wdata = hd;
  endtask

  // Called 1 ns after a rising edge; releases reset mid-cycle.
  task automatic pulse_reset();
    init_n = 1'b0;
    #2;
    init_n = 1'b1;
  endtask

  vec_t vq[$];
  vec_t v;
  obs_t zero_o;
  bit   rv_seen;
  logic [7:0] Z;
  logic [7:0] prev;

  initial begin
    Z = 8'h00;
    zero_o = '0;
    init_n = 1'b0;
    drive(N, Z, Z, N, Z, Z);
    #1;
    check("reset_state", get_obs(), zero_o);
    check_bits("reset_state_prio", {c_gnt1, h_gnt1}, 2'b00);
    @(posedge clk); #1;

    // Core store then load of 0x10.
    vq.push_back(mk(1, S, 8'h10, 8'h5A, N, Z, Z, ob(1,0,1,0,8'h10,8'h5A,0,Z,0,Z)));
    vq.push_back(mk(0, N, Z, Z, N, Z, Z,         ob(0,0,0,0,8'h10,8'h5A,0,Z,0,Z)));
    vq.push_back(mk(0, L, 8'h10, Z, N, Z, Z,     ob(1,0,0,1,8'h10,Z,0,Z,0,Z)));
    vq.push_back(mk(0, N, Z, Z, N, Z, Z,         ob(0,0,0,0,8'h10,Z,0,Z,0,Z)));
    vq.push_back(mk(0, N, Z, Z, N, Z, Z,         ob(0,0,0,0,8'h10,Z,1,8'h5A,0,Z)));
    // Host preload 01..04 at 00..03, then core reads them back.
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(0, N, Z, Z, S, 8'(k), 8'(k+1), ob(0,1,1,0,8'(k),8'(k+1),0,8'h5A,0,Z)));
      vq.push_back(mk(0, N, Z, Z, N, Z, Z,           ob(0,0,0,0,8'(k),8'(k+1),0,8'h5A,0,Z)));
    end
    for (int k = 0; k < 4; k++) begin
      prev = (k == 0) ? 8'h5A : 8'(k);
      vq.push_back(mk(0, L, 8'(k), Z, N, Z, Z, ob(1,0,0,1,8'(k),Z,0,prev,0,Z)));
      vq.push_back(mk(0, N, Z, Z, N, Z, Z,     ob(0,0,0,0,8'(k),Z,0,prev,0,Z)));
      vq.push_back(mk(0, N, Z, Z, N, Z, Z,     ob(0,0,0,0,8'(k),Z,1,8'(k+1),0,Z)));
    end
    vq.push_back(mk(0, N, Z, Z, N, Z, Z, ob(0,0,0,0,8'h03,Z,0,8'h04,0,Z)));
    // Both request stores continuously from reset: C,H,C,H alternating, 2 cycles apart.
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: vq.push_back(mk(i == 0, S, 8'h20, 8'hC1, S, 8'h30, 8'h31, ob(1,0,1,0,8'h20,8'hC1,0,Z,0,Z)));
        1: vq.push_back(mk(0, S, 8'h20, 8'hC1, S, 8'h30, 8'h31,      ob(0,0,0,0,8'h20,8'hC1,0,Z,0,Z)));
        2: vq.push_back(mk(0, S, 8'h20, 8'hC1, S, 8'h30, 8'h31,      ob(0,1,1,0,8'h30,8'h31,0,Z,0,Z)));
        default: vq.push_back(mk(0, S, 8'h20, 8'hC1, S, 8'h30, 8'h31, ob(0,0,0,0,8'h30,8'h31,0,Z,0,Z)));
      endcase
    end
    // Core holds req through its grant; host then arrives and wins the tie.
    vq.push_back(mk(1, S, 8'h40, 8'h44, N, Z, Z,         ob(1,0,1,0,8'h40,8'h44,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, N, Z, Z,         ob(0,0,0,0,8'h40,8'h44,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, N, Z, Z,         ob(1,0,1,0,8'h40,8'h44,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, S, 8'h50, 8'h55, ob(0,0,0,0,8'h40,8'h44,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, S, 8'h50, 8'h55, ob(0,1,1,0,8'h50,8'h55,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, N, Z, Z,         ob(0,0,0,0,8'h50,8'h55,0,Z,0,Z)));
    vq.push_back(mk(0, S, 8'h40, 8'h44, N, Z, Z,         ob(1,0,1,0,8'h40,8'h44,0,Z,0,Z)));
    vq.push_back(mk(0, N, Z, Z, N, Z, Z,                 ob(0,0,0,0,8'h40,8'h44,0,Z,0,Z)));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.rst) init_n = 1'b0;
      c_req = v.creq; c_we = v.cwe; c_addr = v.caddr; c_wdata = v.cwd;
      h_req = v.hreq; h_we = v.hwe; h_addr = v.haddr; h_wdata = v.hwd;
      if (v.rst) begin
        #2;
        init_n = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), get_obs(), v.exp);
    end

    // HOST_PRIO=1: host wins every tie; core served once h_req drops.
    drive(N, Z, Z, N, Z, Z);
    pulse_reset();
    drive(S, 8'h60, 8'h66, S, 8'h70, 8'h77);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      check_bits($sformatf("prio_cyc%0d", j), {c_gnt1, h_gnt1}, (j % 2 == 0) ? 2'b01 : 2'b00);
    end
    h_req = 1'b0;
    @(posedge clk); #1;
    check_bits("prio_after_drop_idle", {c_gnt1, h_gnt1}, 2'b00);
    @(posedge clk); #1;
    check_bits("prio_core_served", {c_gnt1, h_gnt1}, 2'b10);
    drive(N, Z, Z, N, Z, Z);
    @(posedge clk); #1;

    // Reset during RDATA of a core load aborts it without rvalid.
    pulse_reset();
    drive(L, 8'h02, Z, N, Z, Z);
    @(posedge clk); #1;
    check("rst_load_gnt", get_obs(), ob(1,0,0,1,8'h02,Z,0,Z,0,Z));
    drive(N, Z, Z, N, Z, Z);
    @(posedge clk); #1;
    check("rst_load_rdata", get_obs(), ob(0,0,0,0,8'h02,Z,0,Z,0,Z));
    init_n = 1'b0;
    #1;
    check("rst_mid_rdata", get_obs(), zero_o);
    rv_seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      if (c_rvalid0 !== 1'b0) rv_seen = 1'b1;
    end
    #2;
    init_n = 1'b1;
    drive(L, 8'h03, Z, N, Z, Z);
    @(posedge clk); #1;
    if (c_rvalid0 !== 1'b0) rv_seen = 1'b1;
    check("post_rst_gnt", get_obs(), ob(1,0,0,1,8'h03,Z,0,Z,0,Z));
    drive(N, Z, Z, N, Z, Z);
    @(posedge clk); #1;
    if (c_rvalid0 !== 1'b0) rv_seen = 1'b1;
    total_cnt++;
    if (rv_seen !== 1'b0) $display("FAIL no_rvalid_after_abort got rvalid seen=%b want 0", rv_seen);
    else pass_cnt++;
    @(posedge clk); #1;
    check("post_rst_rvalid", get_obs(), ob(0,0,0,0,8'h03,Z,1,8'h04,0,Z));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
